// File: rtl/inst_mem_sync.sv
// Synchronous-read instruction memory for the RISC-V fetch stage: NOP fill after
// reset, run-time program load, and a registered fetch port with stall hold and fault flags.
module inst_mem_sync #(
  parameter int          DEPTH    = 16,
  parameter logic [31:0] NOP_INST = 32'h00000033,
  localparam int         ADDR_W   = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  output logic              ready,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [31:0]       prog_data,
  input  logic              fetch_req,
  input  logic [31:0]       fetch_pc,
  input  logic              fetch_stall,
  output logic              fetch_valid,
  output logic [31:0]       fetch_inst,
  output logic [1:0]        fetch_fault
);

  typedef enum logic [0:0] {
    ST_FILL  = 1'b0,
    ST_READY = 1'b1
  } state_e;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  logic [31:0]       mem_r [DEPTH];
  state_e            state_r;
  logic [ADDR_W-1:0] cnt_r;
  logic              ready_r;
  logic              fetch_valid_r;
  logic [31:0]       fetch_inst_r;
  logic [1:0]        fetch_fault_r;

  logic              wr_en_s;
  logic [ADDR_W-1:0] wr_addr_s;
  logic [31:0]       wr_data_s;
  logic [ADDR_W-1:0] rd_idx_s;
  logic              misaligned_s;
  logic              out_of_range_s;
  logic              fetch_take_s;

  // Range check spans all of fetch_pc[31:2] so high addresses never alias low words
  assign misaligned_s   = (fetch_pc[1:0] != 2'b00);
  assign out_of_range_s = ({2'b00, fetch_pc[31:2]} >= 32'(DEPTH));
  assign rd_idx_s       = fetch_pc[ADDR_W+1:2];
  assign fetch_take_s   = !fetch_valid_r || !fetch_stall;

  // Write-port mux: the fill sequence owns the array until the program port is live
  always_comb begin
    wr_en_s   = 1'b0;
    wr_addr_s = cnt_r;
    wr_data_s = NOP_INST;
    case (state_r)
      ST_FILL: begin
        wr_en_s   = !rst;
        wr_addr_s = cnt_r;
        wr_data_s = NOP_INST;
      end
      ST_READY: begin
        wr_en_s   = prog_we && !rst;
        wr_addr_s = prog_addr;
        wr_data_s = prog_data;
      end
      default: begin
        wr_en_s   = 1'b0;
        wr_addr_s = cnt_r;
        wr_data_s = NOP_INST;
      end
    endcase
  end

  // Instruction array; reset leaves it alone, the fill sequence clears it
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[wr_addr_s] <= wr_data_s;
    end
  end

  // Control FSM and registered fetch result (read-before-write with the array update)
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= ST_FILL;
      cnt_r         <= {ADDR_W{1'b0}};
      ready_r       <= 1'b0;
      fetch_valid_r <= 1'b0;
      fetch_inst_r  <= NOP_INST;
      fetch_fault_r <= 2'b00;
    end else begin
      case (state_r)
        ST_FILL: begin
          cnt_r <= cnt_r + ADDR_W'(1);
          if (cnt_r == LAST_IDX) begin
            state_r <= ST_READY;
            ready_r <= 1'b1;
          end
        end
        ST_READY: begin
          if (fetch_take_s) begin
            if (fetch_req) begin
              fetch_valid_r <= 1'b1;
              fetch_fault_r <= {out_of_range_s, misaligned_s};
              fetch_inst_r  <= (misaligned_s || out_of_range_s) ? NOP_INST : mem_r[rd_idx_s];
            end else begin
              fetch_valid_r <= 1'b0;
            end
          end
        end
        default: begin
          state_r       <= ST_FILL;
          cnt_r         <= {ADDR_W{1'b0}};
          ready_r       <= 1'b0;
          fetch_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign ready       = ready_r;
  assign fetch_valid = fetch_valid_r;
  assign fetch_inst  = fetch_inst_r;
  assign fetch_fault = fetch_fault_r;

endmodule

// File: tb/tb_inst_mem_sync.sv
// Randomised self-checking bench for inst_mem_sync against a behavioural model of
// the fill / program / fetch rules, plus directed scenarios with literal expectations.
module tb_inst_mem_sync;

  localparam int          DEPTH  = 16;
  localparam int          ADDR_W = $clog2(DEPTH);
  localparam logic [31:0] NOP    = 32'h00000033;

  logic              clk;
  logic              rst;
  logic              ready;
  logic              prog_we;
  logic [ADDR_W-1:0] prog_addr;
  logic [31:0]       prog_data;
  logic              fetch_req;
  logic [31:0]       fetch_pc;
  logic              fetch_stall;
  logic              fetch_valid;
  logic [31:0]       fetch_inst;
  logic [1:0]        fetch_fault;

  inst_mem_sync #(.DEPTH(DEPTH), .NOP_INST(NOP)) dut (
    .clk(clk), .rst(rst), .ready(ready),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .fetch_req(fetch_req), .fetch_pc(fetch_pc), .fetch_stall(fetch_stall),
    .fetch_valid(fetch_valid), .fetch_inst(fetch_inst), .fetch_fault(fetch_fault)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model state: what the outputs must be after the next edge
  logic [31:0] model_mem [DEPTH];
  int          fill_left = DEPTH;
  bit          m_ready   = 1'b0;
  bit          exp_valid = 1'b0;
  logic [31:0] exp_inst  = NOP;
  logic [1:0]  exp_fault = 2'b00;
  bit          chk_en    = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    logic [29:0] word;
    bit mis;
    bit oor;
    if (rst) begin
      fill_left = DEPTH;
      m_ready   = 1'b0;
      exp_valid = 1'b0;
      exp_inst  = NOP;
      exp_fault = 2'b00;
      chk_en    = 1'b1;
    end else if (!m_ready) begin
      if (fill_left > 0) fill_left--;
      if (fill_left == 0) begin
        for (int i = 0; i < DEPTH; i++) model_mem[i] = NOP;
        m_ready = 1'b1;
      end
    end else begin
      if (!exp_valid || !fetch_stall) begin
        if (fetch_req) begin
          word = fetch_pc[31:2];
          mis  = (fetch_pc % 4) != 0;
          oor  = word >= DEPTH;
          exp_valid = 1'b1;
          exp_fault = {oor, mis};
          exp_inst  = (mis || oor) ? NOP : model_mem[word];
        end else begin
          exp_valid = 1'b0;
        end
      end
      if (prog_we) model_mem[prog_addr] = prog_data;
    end
  endtask

  // One clock: advance the model, let the DUT take the edge, compare on the falling edge
  task automatic cycle();
    model_step();
    @(posedge clk);
    @(negedge clk);
    if (chk_en) begin
      chk("ready", 32'(ready), 32'(m_ready));
      chk("valid", 32'(fetch_valid), 32'(exp_valid));
      chk("inst", fetch_inst, exp_inst);
      chk("fault", 32'(fetch_fault), 32'(exp_fault));
    end
  endtask

  task automatic set_idle();
    rst = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = 32'h0;
    fetch_req = 1'b0; fetch_pc = 32'h0; fetch_stall = 1'b0;
  endtask

  logic [31:0] prog_words [3] = '{32'h010787B3, 32'h010080B3, 32'h010801B3};
  logic [31:0] fault_pcs  [3] = '{32'h6, 32'h40, 32'h42};
  logic [1:0]  fault_exp  [3] = '{2'b01, 2'b10, 2'b11};

  initial begin
    set_idle();
    rst = 1'b1;
    cycle();
    chk("rst_ready", 32'(ready), 32'h0);
    chk("rst_valid", 32'(fetch_valid), 32'h0);
    chk("rst_inst", fetch_inst, NOP);
    chk("rst_fault", 32'(fetch_fault), 32'h0);
    cycle();

    // Fill: ready rises exactly DEPTH cycles after rst drops
    rst = 1'b0;
    for (int i = 1; i <= DEPTH; i++) begin
      cycle();
      if (i == DEPTH - 1) chk("ready_before_fill_end", 32'(ready), 32'h0);
      if (i == DEPTH)     chk("ready_at_fill_end", 32'(ready), 32'h1);
    end
    for (int i = 0; i < DEPTH; i++) begin
      fetch_req = 1'b1; fetch_pc = 32'(i * 4);
      cycle();
      chk("fill_nop", fetch_inst, NOP);
      chk("fill_valid", 32'(fetch_valid), 32'h1);
    end
    fetch_req = 1'b0;

    // Program three words and fetch them back-to-back
    for (int i = 0; i < 3; i++) begin
      prog_we = 1'b1; prog_addr = ADDR_W'(i); prog_data = prog_words[i];
      cycle();
    end
    prog_we = 1'b0;
    for (int i = 0; i < 3; i++) begin
      fetch_req = 1'b1; fetch_pc = 32'(i * 4);
      cycle();
      chk("prog_fetch", fetch_inst, prog_words[i]);
      chk("prog_valid", 32'(fetch_valid), 32'h1);
    end

    // Faults
    for (int i = 0; i < 3; i++) begin
      fetch_pc = fault_pcs[i];
      cycle();
      chk("fault_inst", fetch_inst, NOP);
      chk("fault_flags", 32'(fetch_fault), 32'(fault_exp[i]));
    end

    // Stall hold
    fetch_pc = 32'h4;
    cycle();
    chk("stall_pre", fetch_inst, 32'h010080B3);
    fetch_stall = 1'b1; fetch_pc = 32'h8;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("stall_hold", fetch_inst, 32'h010080B3);
      chk("stall_valid", 32'(fetch_valid), 32'h1);
    end
    fetch_stall = 1'b0;
    cycle();
    chk("stall_release", fetch_inst, 32'h010801B3);

    // Read/write collision is read-before-write
    prog_we = 1'b1; prog_addr = ADDR_W'(1); prog_data = 32'hDEADBEEF; fetch_pc = 32'h4;
    cycle();
    chk("collide_old", fetch_inst, 32'h010080B3);
    prog_we = 1'b0;
    cycle();
    chk("collide_new", fetch_inst, 32'hDEADBEEF);

    // Randomised traffic, including occasional resets
    for (int n = 0; n < 600; n++) begin
      rst         = ($urandom_range(0, 199) == 0);
      prog_we     = ($urandom_range(0, 3) == 0);
      prog_addr   = ADDR_W'($urandom_range(0, DEPTH - 1));
      prog_data   = $urandom();
      fetch_req   = ($urandom_range(0, 3) != 0);
      fetch_stall = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 7))
        0:       fetch_pc = $urandom();
        1, 2:    fetch_pc = 32'($urandom_range(0, DEPTH * 4 + 15));
        default: fetch_pc = 32'($urandom_range(0, DEPTH - 1)) << 2;
      endcase
      cycle();
    end

    // Return to a ready, idle state (bounded wait)
    set_idle();
    for (int k = 0; k < 3 * DEPTH && !m_ready; k++) cycle();
    chk("ready_after_random", 32'(ready), 32'h1);

    // Reset mid-operation erases the loaded program
    prog_we = 1'b1; prog_addr = ADDR_W'(1); prog_data = 32'h12345678;
    cycle();
    prog_we = 1'b0; fetch_req = 1'b1; fetch_pc = 32'h4;
    cycle();
    chk("pre_rst_inst", fetch_inst, 32'h12345678);
    chk("pre_rst_valid", 32'(fetch_valid), 32'h1);
    rst = 1'b1; fetch_req = 1'b0;
    cycle();
    chk("mid_rst_valid", 32'(fetch_valid), 32'h0);
    chk("mid_rst_ready", 32'(ready), 32'h0);
    chk("mid_rst_inst", fetch_inst, NOP);
    rst = 1'b0;
    for (int i = 1; i <= DEPTH; i++) cycle();
    chk("refill_ready", 32'(ready), 32'h1);
    fetch_req = 1'b1; fetch_pc = 32'h4;
    cycle();
    chk("erased_inst", fetch_inst, NOP);
    chk("erased_valid", 32'(fetch_valid), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/inst_mem_sync.md
Name: inst_mem_sync

Overview:
- Parametrised, synchronous-read instruction memory feeding the RISC-V fetch stage.
- Adds the following on top of a fixed-program memory:
  - a byte-addressed PC;
  - a run-time program-load port;
  - a hardware NOP-fill sequence after reset;
  - a one-cycle registered fetch with stall hold and fault reporting.
- Sits between the PC register and the IF/ID pipeline register.

Parameters:
- DEPTH, 16, number of 32-bit instruction words; power of two, 4..4096.
- ADDR_W, clog2(DEPTH), word-index width (derived; not overridden).
- NOP_INST, 32'h00000033, fill and fault instruction (add x0,x0,x0).

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- ready  out  1  high when fill is complete and fetch/program accepted.
- prog_we  in  1  program-load write strobe.
- prog_addr  in  ADDR_W  word index to write.
- prog_data  in  32  instruction word to write.
- fetch_req  in  1  fetch request for fetch_pc.
- fetch_pc  in  32  byte address of instruction.
- fetch_stall  in  1  downstream stall; hold current fetch output.
- fetch_valid  out  1  fetch_inst/fetch_fault valid.
- fetch_inst  out  32  fetched instruction.
- fetch_fault  out  2  bit0 = misaligned (fetch_pc[1:0]!=0); bit1 = out of range (fetch_pc[31:2] >= DEPTH).

Behaviour:
- Reset (rst=1 at edge):
  - state goes to FILL and fill counter goes to 0.
  - ready=0, fetch_valid=0, fetch_inst=NOP_INST, fetch_fault=0.
  - Array contents are not cleared by reset itself; the FILL state clears them.
- FILL state:
  - Each cycle writes NOP_INST to mem[cnt], then cnt increments.
  - After the write of index DEPTH-1, next state is READY and ready=1.
  - FILL takes exactly DEPTH cycles after rst deasserts.
  - prog_we and fetch_req are ignored; fetch_valid stays 0.
  - rst asserted mid-FILL restarts at cnt=0.
- READY state: remains until rst.
  - Program load:
    - prog_we=1 writes prog_data to mem[prog_addr] at the edge.
    - No handshake; always accepted in READY.
  - Fetch, when fetch_stall=0 or fetch_valid=0:
    - fetch_req=1 registers a result one cycle later (latency 1) and sets fetch_valid=1.
    - If no fault: fetch_inst = mem[fetch_pc[ADDR_W+1:2]] and fetch_fault=0.
    - If any fault bit is set: fetch_inst=NOP_INST and fetch_fault shows the flags; both bits may be set together.
    - fetch_req=0 sets fetch_valid=0 at the next edge; fetch_inst and fetch_fault hold their last values.
  - Stall: when fetch_valid=1 and fetch_stall=1, fetch_valid, fetch_inst and fetch_fault hold unchanged and fetch_req is ignored.
  - Simultaneous prog_we and fetch to the same word in one cycle is read-before-write: the fetch returns the old word, and the new word is visible from the next fetch.
  - prog_we during a stall still writes.
- Address arithmetic:
  - Word index is fetch_pc[ADDR_W+1:2].
  - The range check uses the full fetch_pc[31:2]; there is no wrap-around or aliasing.
- Implementation: single-port-write, single-port-read register array; no combinational path from fetch_pc to fetch_inst.

Test Plan:
- Fill:
  - Stimulus: DEPTH=16; rst=1 for 2 cycles, then 0.
  - Required: ready rises exactly 16 cycles later. Fetches of pc 0x00..0x3C return 32'h00000033 with fault 0, each valid 1 cycle after req.
- Program and fetch:
  - Stimulus: write mem[0]=32'h010787B3, mem[1]=32'h010080B3, mem[2]=32'h010801B3; then fetch pc 0x0, 0x4, 0x8 back-to-back.
  - Required: the three words appear on consecutive cycles with fetch_valid=1.
- Faults:
  - fetch pc 0x6 -> inst NOP, fault=2'b01.
  - fetch pc 0x40 -> inst NOP, fault=2'b10.
  - fetch pc 0x42 -> inst NOP, fault=2'b11.
- Stall:
  - Stimulus: fetch pc 0x4 (valid, inst 32'h010080B3); hold fetch_stall=1 for 3 cycles while fetch_req=1 with pc 0x8.
  - Required: output holds 32'h010080B3 for all 3 cycles; the cycle after stall drops, output shows 32'h010801B3.
- Read/write collision:
  - Stimulus: same cycle, prog_we to mem[1]=32'hDEADBEEF and fetch pc 0x4.
  - Required: result is 32'h010080B3; the next fetch of 0x4 returns 32'hDEADBEEF.
- Reset mid-operation:
  - Stimulus: assert rst during READY with fetch_valid=1.
  - Required: next cycle fetch_valid=0, ready=0, fetch_inst=NOP. After a further 16 cycles, fetch of 0x4 returns NOP (the loaded program is erased).
